arith_rr_scheduler: RTL and testbench
=====================================

// Module: arith_rr_scheduler
// PURPOSE
//  Shares one 4-bit add/subtract datapath (ArithmeticUnit semantics) between NUM_REQ requesters.
//  - Round-robin arbitration; at most one operation issued per cycle.
//  - Registered single-entry response with requester ID.
//  - Sits between client blocks (calculator FSM, test sequencers) and the arithmetic datapath.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  W        4   operand/result width
//  ID_W     2   width of rsp_id; must equal clog2(NUM_REQ)
//  CNT_W    16  width of issued-operation counter
// PORTS
//  clk           in   1            rising-edge clock
//  rst_n         in   1            asynchronous active-low reset
//  req_valid     in   NUM_REQ      per-requester request valid
//  req_ready     out  NUM_REQ      per-requester accept (one-hot or zero)
//  req_a         in   NUM_REQ*W    operand A, requester i at [i*W +: W]
//  req_b         in   NUM_REQ*W    operand B, same packing
//  req_sel       in   NUM_REQ      0 = add, 1 = subtract
//  rsp_valid     out  1            response valid
//  rsp_ready     in   1            response consumer ready
//  rsp_id        out  ID_W         index of requester that issued the op
//  rsp_result    out  W            sum or difference (mod 2^W)
//  rsp_carry     out  1            add: carry out; sub: borrow (A < B unsigned)
//  rsp_overflow  out  1            add: A[W-1]&B[W-1]&~Sum[W-1]; sub: borrow
//  op_count      out  CNT_W        total ops issued since reset, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_overflow=0,
//   op_count=0, rr pointer=0, FSM=IDLE; req_ready=0 while rst_n=0.
//  FSM: IDLE (output register empty) / HOLD (rsp_valid=1).
//   IDLE: any req_valid -> grant, capture, go HOLD. None -> stay.
//   HOLD: rsp_ready=1 & new grant -> stay HOLD with new result (back-to-back, 1 op/cycle);
//         rsp_ready=1 & no grant -> IDLE; rsp_ready=0 -> stay, all outputs stable.
//  Issue condition: can_issue = !rsp_valid | rsp_ready. req_ready is combinational:
//   req_ready[g]=1 only for granted g and only when can_issue; transfer = req_valid[g]&req_ready[g].
//  Arbitration: round-robin starting at ptr; first valid i in ptr, ptr+1, ... (mod NUM_REQ) wins.
//   After a transfer by g, ptr <= (g+1) mod NUM_REQ; ptr unchanged when no transfer.
//  Latency: result visible on rsp_* the cycle after transfer (1 cycle). Throughput 1 op/cycle.
//  Arithmetic: {carry,result} = A+B (W+1 bits) for add; {borrow,result} = A-B for sub,
//   borrow is bit W of the (W+1)-bit difference. Overflow per PORTS column, not signed V.
//  op_count increments by 1 per transfer; 2^CNT_W-1 + 1 -> 0.
//  Simultaneous: rsp handshake and new transfer in the same cycle -> new data replaces old,
//   rsp_valid stays 1, no bubble. Requests dropping req_valid without transfer are legal.
//  Requester must hold req_a/b/sel stable while req_valid=1 and not accepted (not checked).
//  Reset mid-operation: held response discarded, ptr back to 0, no spurious rsp_valid after release.
//  No combinational path rsp_ready -> rsp_* data; rsp_ready -> req_ready path is permitted.
// STRUCTURE
//  Shared package arith_pkg: OP_ADD=1'b0, OP_SUB=1'b1; typedef arith_rsp_t
//   {id, result, carry, overflow}; localparam function clog2 for ID_W checks.
//  One sub-module: arith_rr_arbiter (NUM_REQ) -- req vector + ptr + advance -> one-hot grant, index.
//  Datapath instantiated as existing ArithmeticUnit (W=4) on the muxed granted operands.
//  Top holds FSM, output register, op_count.
// TESTING
//  1. Reset: rst_n=0 mid-run with rsp_valid=1 -> all outputs 0 asynchronously, op_count=0.
//  2. Single req0: A=3,B=2,add -> next cycle rsp_valid=1, id=0, result=5, carry=0, ovf=0;
//     req0 A=3,B=2,sub -> result=1, carry=0.
//  3. Edge arithmetic: add 8+9 -> result=1, carry=1, ovf=1; sub 5-6 -> result=15, carry=1, ovf=1;
//     add 7+5 -> result=12, carry=0, ovf=0.
//  4. Fairness: all 4 req_valid held, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle,
//     op_count=8 after 8 cycles, no bubbles.
//  5. Backpressure: rsp_ready=0 for 5 cycles with rsp_valid=1 -> rsp_* stable, req_ready=0,
//     op_count frozen; rsp_ready=1 -> next grant goes to ptr-ordered requester.
//  6. Sparse: only req2 and req0 valid, ptr=1 -> req2 first then req0; op_count wrap
//     with CNT_W=4 after 16 ops -> 0.

Source files
------------

// File: rtl/arith_pkg.sv
// Purpose: shared opcodes, response record and sizing helper for the arithmetic scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Response record is sized for the largest supported requester count (8) and W=4.
  localparam int RSP_ID_W = 3;
  localparam int RSP_W    = 4;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [RSP_W-1:0]    result;
    logic                carry;
    logic                overflow;
  } arith_rsp_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ArithmeticUnit.sv
// Purpose: W-bit add/subtract with carry/borrow and the add-overflow flag.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module ArithmeticUnit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow
);
  import arith_pkg::*;

  logic [W:0] full;

  // (W+1)-bit sum or difference; bit W is carry for add, borrow for subtract.
  always_comb begin
    if (sel == OP_SUB) full = {1'b0, a} - {1'b0, b};
    else               full = {1'b0, a} + {1'b0, b};
  end

  assign result   = full[W-1:0];
  assign carry    = full[W];
  // Subtract reports borrow here; add flags two set MSBs producing a clear MSB.
  assign overflow = (sel == OP_SUB) ? full[W] : (a[W-1] & b[W-1] & ~full[W-1]);

endmodule

// File: rtl/arith_rr_arbiter.sv
// Purpose: round-robin pick among NUM_REQ requests starting at an internal pointer.
// Latency: grant is combinational; pointer moves on the clock after an advance.
// Backpressure: pointer holds whenever advance is low.
module arith_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);
  logic [ID_W-1:0] ptr_q;
  int              cand;

  // Scan from farthest to nearest candidate so the one closest to ptr wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand[ID_W-1:0];
        grant_any   = 1'b1;
      end
    end
  end

  // After a transfer the requester just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arith_rr_scheduler.sv
// Purpose: shares one add/sub datapath between NUM_REQ requesters, round-robin, tagged response.
// Latency: response registered, visible one cycle after the request transfer; 1 op/cycle.
// Backpressure: rsp_ready low holds the response and forces all req_ready low.
module arith_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W       = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_overflow,
  output logic [CNT_W-1:0]     op_count
);
  import arith_pkg::*;

  if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (W != RSP_W) begin : g_bad_w
    $error("W must match the response record width");
  end

  sched_state_t       state_q, state_d;
  arith_rsp_t         rsp_q, rsp_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               can_issue;
  logic               load;
  logic [W-1:0]       op_a, op_b, alu_result;
  logic               op_sel, alu_carry, alu_overflow;

  arith_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign op_a   = req_a[int'(grant_idx)*W +: W];
  assign op_b   = req_b[int'(grant_idx)*W +: W];
  assign op_sel = req_sel[grant_idx];

  ArithmeticUnit #(.W(W)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .sel      (op_sel),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow)
  );

  // Next state: an empty or draining output register may accept a new op.
  always_comb begin
    state_d   = state_q;
    can_issue = 1'b0;
    case (state_q)
      IDLE: begin
        can_issue = 1'b1;
        if (grant_any) state_d = HOLD;
      end
      HOLD: begin
        can_issue = rsp_ready;
        if (rsp_ready && !grant_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load      = can_issue & grant_any & rst_n;
  assign req_ready = load ? grant : '0;

  // Next response record captured from the granted requester's datapath result.
  always_comb begin
    rsp_d          = '0;
    rsp_d.id       = RSP_ID_W'(grant_idx);
    rsp_d.result   = alu_result;
    rsp_d.carry    = alu_carry;
    rsp_d.overflow = alu_overflow;
  end

  // State, response register and issued-op counter; replacement on a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rsp_q    <= '0;
      op_count <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rsp_q    <= rsp_d;
        op_count <= op_count + 1'b1;
      end
    end
  end

  assign rsp_valid    = (state_q == HOLD);
  assign rsp_id       = ID_W'(rsp_q.id);
  assign rsp_result   = rsp_q.result;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_overflow = rsp_q.overflow;

endmodule

// File: tb/tb_arith_rr_scheduler.sv
// Purpose: directed and randomized check of arith_rr_scheduler against a behavioural model.
// Latency: model expects results one cycle after each accepted request.
// Backpressure: random rsp_ready stalls; requesters hold operands until accepted.
module tb_arith_rr_scheduler;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [15:0]   req_a, req_b;
  logic [NR-1:0] req_sel;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [3:0]    rsp_result;
  logic          rsp_carry, rsp_overflow;
  logic [3:0]    op_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_ptr, m_id, m_res, m_count, m_last;
  bit m_valid, m_carry, m_ovf;

  arith_rr_scheduler #(.NUM_REQ(4), .W(4), .ID_W(2), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic calc(input int a, input int b, input bit sub,
                      output int r, output bit c, output bit v);
    if (!sub) begin
      r = (a + b) % 16;
      c = (a + b) >= 16;
      v = (a >= 8) && (b >= 8) && (r < 8);
    end else begin
      r = (a - b + 16) % 16;
      c = a < b;
      v = c;
    end
  endtask

  function automatic int model_grant();
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < NR; k++)
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = 0;
    m_carry = 0; m_ovf = 0; m_count = 0; m_last = -1;
  endtask

  // One cycle: compare at negedge+1, advance the model on the posedge, return at negedge.
  task automatic step();
    int g;
    logic [3:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_result", 32'(rsp_result), m_res);
      chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
      chk("rsp_overflow", 32'(rsp_overflow), 32'(m_ovf));
    end
    chk("op_count", 32'(op_count), m_count % 16);
    @(posedge clk);
    if (g >= 0) begin
      calc(int'(req_a[g*4 +: 4]), int'(req_b[g*4 +: 4]), req_sel[g], m_res, m_carry, m_ovf);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NR;
      m_count = m_count + 1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    m_last = g;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b, input bit s);
    req_valid[i]   = v;
    req_a[i*4 +: 4] = 4'(a);
    req_b[i*4 +: 4] = 4'(b);
    req_sel[i]     = s;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < NR; i++) begin
      if (!(req_valid[i] && m_last != i && $urandom_range(0, 9) != 0))
        set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    model_reset();
    @(negedge clk); #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_op_count", 32'(op_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single requester 0: add then subtract
    set_req(0, 1, 3, 2, 0); step();
    chk("lit_add_result", 32'(rsp_result), 5);
    chk("lit_add_id", 32'(rsp_id), 0);
    set_req(0, 1, 3, 2, 1); step();
    chk("lit_sub_result", 32'(rsp_result), 1);
    chk("lit_sub_carry", 32'(rsp_carry), 0);

    // Edge arithmetic
    set_req(0, 1, 8, 9, 0); step();
    chk("lit_8p9", 32'({rsp_result, rsp_carry, rsp_overflow}), 32'({4'd1, 1'b1, 1'b1}));
    set_req(0, 1, 5, 6, 1); step();
    chk("lit_5m6", 32'({rsp_result, rsp_carry, rsp_overflow}), 32'({4'd15, 1'b1, 1'b1}));
    set_req(0, 1, 7, 5, 0); step();
    chk("lit_7p5", 32'({rsp_result, rsp_carry, rsp_overflow}), 32'({4'd12, 1'b0, 1'b0}));

    // Hold a response, then reset mid-operation
    req_valid = '0; rsp_ready = 1'b0;
    step(); step();
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_rsp_data", 32'({rsp_id, rsp_result, rsp_carry, rsp_overflow}), 0);
    chk("arst_op_count", 32'(op_count), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_valid = '0; rsp_ready = 1'b1;
    step();
    #1 chk("no_spurious_valid", 32'(rsp_valid), 0);
    @(negedge clk);

    // Fairness: all requesting, no stalls
    for (int i = 0; i < NR; i++) set_req(i, 1, i + 1, 2 * i, i % 2);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_id", 32'(rsp_id), k % 4);
    end
    chk("fair_count", 32'(op_count), 8);

    // Backpressure
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    #1;
    chk("bp_req_ready", 32'(req_ready), 0);
    chk("bp_count", 32'(op_count), 8);
    chk("bp_id", 32'(rsp_id), 3);
    @(negedge clk);
    rsp_ready = 1'b1;
    step();
    chk("bp_release_id", 32'(rsp_id), 0);

    // Sparse: only 2 and 0 with ptr at 1
    req_valid = 4'b0101;
    step();
    chk("sparse_first", 32'(rsp_id), 2);
    step();
    chk("sparse_second", 32'(rsp_id), 0);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) step();
    chk("count_wrap", 32'(op_count), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
